// File: rtl/md_arb_if.sv
// md_io: shared single-writer bus carrying a write strobe and an 8-bit address/data byte.
interface md_io;
    logic       we;
    logic [7:0] ai;

    modport master (output we, ai);
    modport slave  (input  we, ai);
endinterface

// File: rtl/md_arb.sv
// md_arb: round-robin arbiter sharing one md_io master port between N requesters.
// Optional: define MD_ARB_PRIO_EN to give requester 0 fixed priority at arbitration time.
module md_arb #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         last,
    input  logic [N-1:0]         req_we,
    input  logic [8*N-1:0]       req_ai,
    output logic [N-1:0]         gnt,
    md_io.master                 md_if,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int OW = $clog2(N);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);
    localparam logic [7:0]   BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    ai_q, ai_d;
    logic          we_q, we_d;
    logic [OW-1:0] winner, arb_idx;
    logic          found, done;

    // Winner search: first requester at or after the rr pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch can be inferred.
        found   = 1'b0;
        winner  = '0;
        arb_idx = '0;
`ifdef MD_ARB_PRIO_EN
        if (req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                arb_idx = OW'(1 + (((rr_q == '0 ? 1 : int'(rr_q)) - 1 + k) % (N - 1)));
                if (!found && req[arb_idx]) begin
                    found  = 1'b1;
                    winner = arb_idx;
                end
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            arb_idx = OW'((int'(rr_q) + k) % N);
            if (!found && req[arb_idx]) begin
                found  = 1'b1;
                winner = arb_idx;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        ai_d    = ai_q;
        done    = 1'b0;
        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = ONE_HOT0 << winner;
                    owner_d = winner;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                we_d = req_we[owner_q] & req[owner_q];
                if (we_d) begin
                    ai_d = req_ai[8*int'(owner_q) +: 8];
                end
                if (cnt_q != BURST_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // A dropped request ends the burst without transferring that cycle.
                done = !req[owner_q] || last[owner_q] || (cnt_q == BURST_MAX);
                if (done) begin
                    gnt_d   = '0;
                    rr_d    = OW'((int'(owner_q) + 1) % N);
                    state_d = TURN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ai_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ai_q    <= ai_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign md_if.we  = we_q;
    assign md_if.ai  = ai_q;
endmodule

// File: tb/tb_md_arb.sv
// tb_md_arb: table-driven, scoreboard-checked bench for md_arb (N=4, MAX_BURST=4).
module tb_md_arb;
    localparam int N  = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, last, req_we;
    logic [8*N-1:0]  req_ai;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            busy;

    md_io md_if ();

    md_arb #(.N(N), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .last   (last),
        .req_we (req_we),
        .req_ai (req_ai),
        .gnt    (gnt),
        .md_if  (md_if),
        .owner  (owner),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  l;
        logic [3:0]  w;
        logic [31:0] a;
        logic [15:0] e;
        string       nm;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    // Expected-output bundle: {gnt, we, ai, owner, busy}.
    function automatic logic [15:0] pk(input logic [3:0] g, input logic w, input logic [7:0] a,
                                       input logic [1:0] o, input logic b);
        return {g, w, a, o, b};
    endfunction

    function automatic logic [15:0] obs();
        return {gnt, md_if.we, md_if.ai, owner, busy};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {gnt,we,ai,owner,busy}=%h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic [3:0] r, input logic [3:0] l,
                                input logic [3:0] w, input logic [31:0] a, input logic [15:0] e);
        vec_t v;
        v.r = r; v.l = l; v.w = w; v.a = a; v.e = e; v.nm = nm;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs();
        logic [15:0] exp;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req = vecs[i].r; last = vecs[i].l; req_we = vecs[i].w; req_ai = vecs[i].a;
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            check(vecs[i].nm, obs(), exp);
        end
        vecs.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; last = '0; req_we = '0; req_ai = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), pk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // gnt must never have more than one bit set.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("FAIL gnt_onehot: got gnt=%b required at most one bit", gnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = '0; last = '0; req_we = '0; req_ai = '0;
        #1;
        check("reset_async_t0", obs(), pk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
        apply_reset();

        // Single requester 2 for 10 cycles: 1111 0 1111 0 on we.
        add("r2_grant", 4'b0100, 4'b0000, 4'b0100, 32'h0021_0000, pk(4'b0100, 1'b0, 8'h00, 2'd2, 1'b1));
        add("r2_w1",    4'b0100, 4'b0000, 4'b0100, 32'h0022_0000, pk(4'b0100, 1'b1, 8'h22, 2'd2, 1'b1));
        add("r2_w2",    4'b0100, 4'b0000, 4'b0100, 32'h0023_0000, pk(4'b0100, 1'b1, 8'h23, 2'd2, 1'b1));
        add("r2_w3",    4'b0100, 4'b0000, 4'b0100, 32'h0024_0000, pk(4'b0100, 1'b1, 8'h24, 2'd2, 1'b1));
        add("r2_w4rel", 4'b0100, 4'b0000, 4'b0100, 32'h0025_0000, pk(4'b0000, 1'b1, 8'h25, 2'd2, 1'b1));
        add("r2_turn",  4'b0100, 4'b0000, 4'b0100, 32'h0026_0000, pk(4'b0100, 1'b0, 8'h25, 2'd2, 1'b1));
        add("r2_w5",    4'b0100, 4'b0000, 4'b0100, 32'h0027_0000, pk(4'b0100, 1'b1, 8'h27, 2'd2, 1'b1));
        add("r2_w6",    4'b0100, 4'b0000, 4'b0100, 32'h0028_0000, pk(4'b0100, 1'b1, 8'h28, 2'd2, 1'b1));
        add("r2_w7",    4'b0100, 4'b0000, 4'b0100, 32'h0029_0000, pk(4'b0100, 1'b1, 8'h29, 2'd2, 1'b1));
        add("r2_w8rel", 4'b0100, 4'b0000, 4'b0100, 32'h002A_0000, pk(4'b0000, 1'b1, 8'h2A, 2'd2, 1'b1));
        add("r2_idle",  4'b0000, 4'b0000, 4'b0000, 32'h002B_0000, pk(4'b0000, 1'b0, 8'h2A, 2'd2, 1'b0));
        // Requester 1 with last on 0x09; other requesters' last/we/ai must be ignored.
        add("r1_grant", 4'b0010, 4'b0000, 4'b0010, 32'h0000_0700, pk(4'b0010, 1'b0, 8'h2A, 2'd1, 1'b1));
        add("r1_w08",   4'b0010, 4'b1000, 4'b1011, 32'hEEEE_08EE, pk(4'b0010, 1'b1, 8'h08, 2'd1, 1'b1));
        add("r1_w09",   4'b0010, 4'b0010, 4'b0010, 32'h0000_0900, pk(4'b0000, 1'b1, 8'h09, 2'd1, 1'b1));
        add("r1_idle",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, pk(4'b0000, 1'b0, 8'h09, 2'd1, 1'b0));
        // Requester 3 drops req after 2 transfers.
        add("r3_grant", 4'b1000, 4'b0000, 4'b1000, 32'h3100_0000, pk(4'b1000, 1'b0, 8'h09, 2'd3, 1'b1));
        add("r3_w1",    4'b1000, 4'b0000, 4'b1000, 32'h3200_0000, pk(4'b1000, 1'b1, 8'h32, 2'd3, 1'b1));
        add("r3_w2",    4'b1000, 4'b0000, 4'b1000, 32'h3300_0000, pk(4'b1000, 1'b1, 8'h33, 2'd3, 1'b1));
        add("r3_drop",  4'b0000, 4'b0000, 4'b1000, 32'h3400_0000, pk(4'b0000, 1'b0, 8'h33, 2'd3, 1'b1));
        add("r3_idle",  4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, pk(4'b0000, 1'b0, 8'h33, 2'd3, 1'b0));
        // Pointer is 0 now; set it to 2 with owner 1 mid-burst (counter=2).
        add("x1_grant", 4'b0010, 4'b0000, 4'b0010, 32'h0000_5100, pk(4'b0010, 1'b0, 8'h33, 2'd1, 1'b1));
        add("x1_w1",    4'b0010, 4'b0000, 4'b0010, 32'h0000_5200, pk(4'b0010, 1'b1, 8'h52, 2'd1, 1'b1));
        add("x1_last",  4'b0010, 4'b0010, 4'b0010, 32'h0000_5300, pk(4'b0000, 1'b1, 8'h53, 2'd1, 1'b1));
        add("x1_regnt", 4'b0010, 4'b0000, 4'b0010, 32'h0000_5400, pk(4'b0010, 1'b0, 8'h53, 2'd1, 1'b1));
        add("x1_w2",    4'b0010, 4'b0000, 4'b0010, 32'h0000_5500, pk(4'b0010, 1'b1, 8'h55, 2'd1, 1'b1));
        run_vecs();

        // Asynchronous reset in the middle of a clock period.
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", obs(), pk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0110; req_we = 4'b0110; req_ai = 32'h0000_0000; last = '0;
        @(posedge clk);
        #1;
        check("rst_ptr_cleared", obs(), pk(4'b0010, 1'b0, 8'h00, 2'd1, 1'b1));
        apply_reset();

`ifdef MD_ARB_PRIO_EN
        // Requester 0 keeps winning while it requests; 2 waits until req[0] drops.
        add("p_grant0", 4'b0101, 4'b0000, 4'b0101, 32'h0042_0040, pk(4'b0001, 1'b0, 8'h00, 2'd0, 1'b1));
        for (int g = 0; g < 3; g++) begin
            for (int c = 1; c <= MB; c++) begin
                add($sformatf("p_b%0d_c%0d", g, c), 4'b0101, 4'b0000, 4'b0101, 32'h0042_0040,
                    pk((c < MB) ? 4'b0001 : 4'b0000, 1'b1, 8'h40, 2'd0, 1'b1));
            end
            if (g < 2)
                add($sformatf("p_turn%0d", g), 4'b0101, 4'b0000, 4'b0101, 32'h0042_0040,
                    pk(4'b0001, 1'b0, 8'h40, 2'd0, 1'b1));
            else
                add("p_turn_r2", 4'b0100, 4'b0000, 4'b0100, 32'h0042_0040,
                    pk(4'b0100, 1'b0, 8'h40, 2'd2, 1'b1));
        end
        add("p_r2_w", 4'b0100, 4'b0000, 4'b0100, 32'h0042_0040, pk(4'b0100, 1'b1, 8'h42, 2'd2, 1'b1));
`else
        // All four requesting from reset: grants 0,1,2,3,0 with one bubble between bursts.
        add("rr_grant0", 4'b1111, 4'b0000, 4'b1111, 32'h4342_4140, pk(4'b0001, 1'b0, 8'h00, 2'd0, 1'b1));
        for (int o = 0; o < N; o++) begin
            for (int c = 1; c <= MB; c++) begin
                add($sformatf("rr_o%0d_c%0d", o, c), 4'b1111, 4'b0000, 4'b1111, 32'h4342_4140,
                    pk((c < MB) ? 4'(1 << o) : 4'b0000, 1'b1, 8'(8'h40 + o), 2'(o), 1'b1));
            end
            add($sformatf("rr_turn%0d", o), 4'b1111, 4'b0000, 4'b1111, 32'h4342_4140,
                pk(4'(1 << ((o + 1) % N)), 1'b0, 8'(8'h40 + o), 2'((o + 1) % N), 1'b1));
        end
`endif
        run_vecs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
